// File: rtl/rom_arb_mem.sv
// Shared word array with two request/grant ports (rib, core), byte-lane writes,
// registered read response and starvation-bounded fixed-priority arbitration.
// Optional core write protection is enabled with `define ROM_WP_EN.
module rom_arb_mem #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ROM_WP_EN
    input  logic                wp_set_i,
    input  logic                wp_clr_i,
`endif
    input  logic                rib_req_i,
    input  logic                rib_we_i,
    input  logic [DATA_W/8-1:0] rib_be_i,
    input  logic [ADDR_W-1:0]   rib_addr_i,
    input  logic [DATA_W-1:0]   rib_data_i,
    output logic                rib_gnt_o,
    output logic                rib_rvalid_o,
    output logic [DATA_W-1:0]   rib_data_o,
    output logic                rib_err_o,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_data_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_data_o,
    output logic                core_err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]      STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [ADDR_W:0] DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [7:0]        starve_cnt;
    logic              core_prio;
    logic              rib_gnt;
    logic              core_gnt;

    logic              acc_valid;
    logic              acc_we;
    logic [BE_W-1:0]   acc_be;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              acc_in_range;
    logic              wp_block;
    logic              commit;

    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_data;
    logic              resp_zero_q;
    logic              resp_err_q;
    logic              rib_rvalid_q;
    logic              core_rvalid_q;
    logic [DATA_W-1:0] rib_data_hold_q;
    logic [DATA_W-1:0] core_data_hold_q;
    logic              rib_err_hold_q;
    logic              core_err_hold_q;

    // Rib wins by default; a core that has waited STARVE_MAX cycles takes priority.
    always_comb begin
        core_prio = 1'b0;
        rib_gnt   = 1'b0;
        core_gnt  = 1'b0;
        if (!rst) begin
            core_prio = core_req_i && (starve_cnt == STARVE_LIM);
            rib_gnt   = rib_req_i && !core_prio;
            core_gnt  = core_req_i && (core_prio || !rib_req_i);
        end
    end

    assign rib_gnt_o  = rib_gnt;
    assign core_gnt_o = core_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!core_req_i || core_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_comb begin
        acc_valid = rib_gnt || core_gnt;
        acc_we    = rib_we_i;
        acc_be    = rib_be_i;
        acc_addr  = rib_addr_i;
        acc_wdata = rib_data_i;
        if (core_gnt) begin
            acc_we    = core_we_i;
            acc_be    = core_be_i;
            acc_addr  = core_addr_i;
            acc_wdata = core_data_i;
        end
    end

    // Low address bits select a byte within the word and are ignored.
    assign acc_idx      = acc_addr >> OFF_W;
    assign mem_idx      = acc_idx[IDX_W-1:0];
    assign acc_in_range = ({1'b0, acc_idx} < DEPTH_EXT);

`ifdef ROM_WP_EN
    logic wp_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_lock <= 1'b0;
        end else if (wp_set_i) begin
            wp_lock <= 1'b1;
        end else if (wp_clr_i) begin
            wp_lock <= 1'b0;
        end
    end

    assign wp_block = core_gnt && core_we_i && wp_lock;
`else
    assign wp_block = 1'b0;
`endif

    assign commit = acc_valid && acc_we && acc_in_range && !wp_block;

    // Read-first array: a read returns the word as it stood before this edge.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) begin
                    mem[mem_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                end
            end
        end
        if (acc_valid && !acc_we && acc_in_range) begin
            rd_q <= mem[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rib_rvalid_q     <= 1'b0;
            core_rvalid_q    <= 1'b0;
            resp_zero_q      <= 1'b1;
            resp_err_q       <= 1'b0;
            rib_data_hold_q  <= '0;
            core_data_hold_q <= '0;
            rib_err_hold_q   <= 1'b0;
            core_err_hold_q  <= 1'b0;
        end else begin
            rib_rvalid_q     <= rib_gnt;
            core_rvalid_q    <= core_gnt;
            if (acc_valid) begin
                resp_zero_q <= acc_we || !acc_in_range;
                resp_err_q  <= !acc_in_range || wp_block;
            end
            rib_data_hold_q  <= rib_data_o;
            core_data_hold_q <= core_data_o;
            rib_err_hold_q   <= rib_err_o;
            core_err_hold_q  <= core_err_o;
        end
    end

    // Each port shows the fresh response while rvalid is high, otherwise its held value.
    assign rd_data       = resp_zero_q ? '0 : rd_q;
    assign rib_rvalid_o  = rib_rvalid_q;
    assign core_rvalid_o = core_rvalid_q;
    assign rib_data_o    = rib_rvalid_q  ? rd_data    : rib_data_hold_q;
    assign core_data_o   = core_rvalid_q ? rd_data    : core_data_hold_q;
    assign rib_err_o     = rib_rvalid_q  ? resp_err_q : rib_err_hold_q;
    assign core_err_o    = core_rvalid_q ? resp_err_q : core_err_hold_q;

endmodule

// File: tb/tb_rom_arb_mem.sv
// Self-checking bench for rom_arb_mem: directed scenarios plus randomized traffic
// compared against a behavioural model of memory, arbitration and responses.
module tb_rom_arb_mem;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4096;
    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wp_set = 1'b0;
    logic        wp_clr = 1'b0;
    logic        rib_req = 1'b0, rib_we = 1'b0;
    logic [3:0]  rib_be = '0;
    logic [31:0] rib_addr = '0, rib_wdata = '0;
    logic        rib_gnt, rib_rvalid, rib_err;
    logic [31:0] rib_rdata;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [3:0]  core_be = '0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem_model [DEPTH];
    int          waited = 0;
    bit          wp_lock_m = 1'b0;
    bit          exp_rib_rvalid = 1'b0, exp_core_rvalid = 1'b0;
    bit          exp_rib_err = 1'b0, exp_core_err = 1'b0;
    logic [31:0] exp_rib_data = '0, exp_core_data = '0;
    bit          obs_rib_gnt, obs_core_gnt;

    always #5 clk = ~clk;

    rom_arb_mem #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef ROM_WP_EN
        .wp_set_i(wp_set),
        .wp_clr_i(wp_clr),
`endif
        .rib_req_i(rib_req), .rib_we_i(rib_we), .rib_be_i(rib_be),
        .rib_addr_i(rib_addr), .rib_data_i(rib_wdata),
        .rib_gnt_o(rib_gnt), .rib_rvalid_o(rib_rvalid),
        .rib_data_o(rib_rdata), .rib_err_o(rib_err),
        .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
        .core_addr_i(core_addr), .core_data_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
        .core_data_o(core_rdata), .core_err_o(core_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Behavioural access: word = addr/4, range checked, write-protect on core writes.
    function automatic void modelAccess(input bit we, input logic [3:0] be, input logic [31:0] addr,
                                        input logic [31:0] wdata, input bit is_core,
                                        output logic [31:0] rdata, output bit err);
        int unsigned idx;
        bit in_range, blocked;
        logic [31:0] mask;
        idx = addr / 4;
        in_range = (idx < DEPTH);
        blocked = is_core && we && wp_lock_m;
        err = !in_range || blocked;
        rdata = (!we && in_range) ? mem_model[idx] : 32'h0;
        if (we && in_range && !blocked) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
            mem_model[idx] = (mem_model[idx] & ~mask) | (wdata & mask);
        end
    endfunction

    task automatic applyStimulus(input bit r_req, input bit r_we, input logic [3:0] r_be,
                                 input logic [31:0] r_addr, input logic [31:0] r_data,
                                 input bit c_req, input bit c_we, input logic [3:0] c_be,
                                 input logic [31:0] c_addr, input logic [31:0] c_data);
        bit e_rg, e_cg;
        rib_req = r_req; rib_we = r_we; rib_be = r_be; rib_addr = r_addr; rib_wdata = r_data;
        core_req = c_req; core_we = c_we; core_be = c_be; core_addr = c_addr; core_wdata = c_data;
        @(negedge clk);
        e_rg = 1'b0;
        e_cg = 1'b0;
        if (!rst) begin
            if (c_req && waited == STARVE_MAX) e_cg = 1'b1;
            else if (r_req) e_rg = 1'b1;
            else if (c_req) e_cg = 1'b1;
        end
        obs_rib_gnt  = rib_gnt;
        obs_core_gnt = core_gnt;
        checkOutput("rib_gnt", 32'(rib_gnt), 32'(e_rg));
        checkOutput("core_gnt", 32'(core_gnt), 32'(e_cg));
        checkOutput("rib_rvalid", 32'(rib_rvalid), 32'(exp_rib_rvalid));
        checkOutput("rib_data", rib_rdata, exp_rib_data);
        checkOutput("rib_err", 32'(rib_err), 32'(exp_rib_err));
        checkOutput("core_rvalid", 32'(core_rvalid), 32'(exp_core_rvalid));
        checkOutput("core_data", core_rdata, exp_core_data);
        checkOutput("core_err", 32'(core_err), 32'(exp_core_err));
        if (rst) begin
            waited = 0;
            wp_lock_m = 1'b0;
            exp_rib_rvalid = 1'b0; exp_rib_data = '0; exp_rib_err = 1'b0;
            exp_core_rvalid = 1'b0; exp_core_data = '0; exp_core_err = 1'b0;
        end else begin
            if (!c_req || e_cg) waited = 0;
            else if (waited < STARVE_MAX) waited++;
            exp_rib_rvalid = e_rg;
            exp_core_rvalid = e_cg;
            if (e_rg) modelAccess(r_we, r_be, r_addr, r_data, 1'b0, exp_rib_data, exp_rib_err);
            if (e_cg) modelAccess(c_we, c_be, c_addr, c_data, 1'b1, exp_core_data, exp_core_err);
`ifdef ROM_WP_EN
            if (wp_set) wp_lock_m = 1'b1;
            else if (wp_clr) wp_lock_m = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pickAddr(input int k);
        logic [31:0] a;
        if (k < 16) a = 32'(k * 4);
        else if (k == 16) a = 32'((DEPTH - 1) * 4);
        else if (k == 17) a = 32'(DEPTH * 4);
        else if (k == 18) a = 32'((DEPTH + 7) * 4);
        else a = 32'hFFFF_FFFC;
        return a | 32'($urandom_range(0, 3));
    endfunction

    task automatic idle();
        applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset_rib_rvalid", 32'(rib_rvalid), 0);
        checkOutput("reset_rib_data", rib_rdata, 0);
        checkOutput("reset_core_err", 32'(core_err), 0);
        idle();
        rst = 1'b0;

        // Preload every in-range word the bench ever touches.
        for (int k = 0; k < 17; k++)
            applyStimulus(1, 1, 4'hF, pickAddr(k), $urandom, 0, 0, 4'h0, 0, 0);

        applyStimulus(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h10, 32'hA5A5_5A5A);
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h10, 0);
        checkOutput("basic_rvalid", 32'(core_rvalid), 1);
        checkOutput("basic_rdata", core_rdata, 32'hA5A5_5A5A);
        checkOutput("basic_err", 32'(core_err), 0);

        applyStimulus(1, 1, 4'hF, 32'h20, 32'h1122_3344, 0, 0, 4'h0, 0, 0);
        applyStimulus(1, 1, 4'b0010, 32'h20, 32'h0000_FF00, 0, 0, 4'h0, 0, 0);
        applyStimulus(1, 0, 4'h0, 32'h20, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("bytelane_rdata", rib_rdata, 32'h1122_FF44);

        idle();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, 0, 4'h0, 32'h0, 0, 1, 0, 4'h0, 32'h4, 0);
            checkOutput("starve_core_gnt", 32'(obs_core_gnt), 32'(c == 4));
            checkOutput("starve_rib_gnt", 32'(obs_rib_gnt), 32'(c != 4));
        end
        idle();

        applyStimulus(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h4000, 0);
        checkOutput("oor_rvalid", 32'(core_rvalid), 1);
        checkOutput("oor_data", core_rdata, 0);
        checkOutput("oor_err", 32'(core_err), 1);
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h4000, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h0, 0);
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'((DEPTH - 1) * 4), 0);
        idle();

        applyStimulus(1, 0, 4'h0, 32'h20, 0, 0, 0, 4'h0, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 0, 4'h0, 32'h10, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("rst_rib_gnt", 32'(obs_rib_gnt), 0);
        checkOutput("rst_rvalid", 32'(rib_rvalid), 0);
        checkOutput("rst_data", rib_rdata, 0);
        rst = 1'b0;
        applyStimulus(1, 0, 4'h0, 32'h10, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("post_rst_data", rib_rdata, 32'hA5A5_5A5A);

`ifdef ROM_WP_EN
        wp_set = 1'b1;
        idle();
        wp_set = 1'b0;
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        checkOutput("wp_err", 32'(core_err), 1);
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h10, 0);
        checkOutput("wp_old_data", core_rdata, 32'hA5A5_5A5A);
        applyStimulus(1, 1, 4'hF, 32'h10, 32'hCAFE_F00D, 0, 0, 4'h0, 0, 0);
        applyStimulus(1, 0, 4'h0, 32'h10, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("wp_rib_write", rib_rdata, 32'hCAFE_F00D);
        wp_clr = 1'b1;
        idle();
        wp_clr = 1'b0;
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h10, 32'h1234_5678);
        applyStimulus(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h10, 0);
        checkOutput("wp_clr_write", core_rdata, 32'h1234_5678);
`endif

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) == 0);
`ifdef ROM_WP_EN
            wp_set = ($urandom_range(0, 19) == 0);
            wp_clr = ($urandom_range(0, 19) == 0);
`endif
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 4'($urandom),
                          pickAddr($urandom_range(0, 19)), $urandom,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 4'($urandom),
                          pickAddr($urandom_range(0, 19)), $urandom);
        end
        rst = 1'b0;
        wp_set = 1'b0;
        wp_clr = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
